seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Consumes the BCD digits produced by the clock/alarm timekeeping block and drives a time-multiplexed common-segment 6-digit seven-segment display. Latches a tear-free snapshot per frame, scans one digit at a time with dead-time between digits, and supports per-digit blinking for set modes and leading-zero blanking for the hour tens digit. Sits between the timekeeper outputs and the board display pins.

Parameters:
DIGITS, 6, number of scanned digits; digit 0 = seconds ones, digit DIGITS-1 = hour tens
SCAN_DIV, 4, clk cycles each digit is lit (must be >= 4)
BLINK_HALF, 250, clk cycles per blink half-period (2 Hz at 1000 Hz clk)

Ports:
clk  in  1  main clock
rst  in  1  asynchronous reset, active-low
enable  in  1  1 = scanning; 0 = display dark
bcd_in  in  4*DIGITS  packed BCD, digit i at bits [4i+3:4i]
blink_mask  in  DIGITS  1 = digit i blinks
blank_lz  in  1  1 = blank digit DIGITS-1 when its value is 0
dp_mask  in  DIGITS  decimal point per digit
seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high
dp_out  out  1  decimal point, active-high
dig_sel  out  DIGITS  one-hot digit enable, active-high
frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset: seg_out=0, dp_out=0, dig_sel=0, frame_tick=0, state=IDLE, digit index=0, div counter=0, blink counter=0, blink_phase=0 (visible), snapshot=0.
- FSM states: IDLE, SHOW, GAP.
- IDLE: all outputs 0. When enable=1, go to SHOW on the next cycle, with digit index 0. On that entry cycle, latch the snapshot (bcd_in, blink_mask, blank_lz, dp_mask) and pulse frame_tick.
- SHOW: dig_sel=one-hot(index). seg_out/dp_out come from the registered decode of the snapshot digit. Stay for exactly SCAN_DIV cycles, then go to GAP.
- GAP: one cycle with dig_sel=0, seg_out=0, dp_out=0 (ghosting dead-time).
  - If index=DIGITS-1: wrap index to 0, re-latch the snapshot, pulse frame_tick, go to SHOW.
  - Otherwise: index+1, go to SHOW.
- Frame length = DIGITS*(SCAN_DIV+1) cycles (30 at defaults).
- enable=0 in any state: go to IDLE on the next edge, outputs 0 that cycle. Re-enabling always restarts at digit 0 with a fresh snapshot.
- Decode (gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Codes 10–15 = 1000000 (dash, error indication).
- Blanking: seg_out=0 and dp_out=0 while dig_sel stays asserted, when either holds:
  - blink_mask[i]=1 and blink_phase=1
  - i=DIGITS-1, blank_lz=1 and the digit value is 0
- Blink counter: free-running while rst is high, independent of enable. It counts 0..BLINK_HALF-1; on wrap, blink_phase toggles.
- All outputs are registered; no combinational path from inputs to outputs.
- Input changes mid-frame have no visible effect until the next snapshot.

Optional Feature:
SEG_DIMMING_EN — adds input brightness[1:0].
- Defined: within SHOW, segments and dp are driven only while the div counter < ((brightness+1)*SCAN_DIV)/4. Outside that window seg_out=0 and dp_out=0, while dig_sel stays asserted. brightness=3 gives full on. brightness is sampled with the snapshot.
- Undefined: the port is absent and behaviour is full on.

Decomposition:
- Package seg_pkg: SEG_0..SEG_9, SEG_DASH, SEG_BLANK constants; scan_state_t enum {IDLE, SHOW, GAP}.
- One sub-module, bcd_to_seg7: combinational 4-bit BCD to 7-bit decode using the pkg constants. It is instantiated once on the muxed snapshot digit.

Test Plan:
- Reset release, enable=1, bcd_in=0x235959, masks 0, BLINK_HALF set large enough that blink_phase stays 0 for the test window → frame_tick at cycle 1; dig_sel 000001 with seg 1101111 for 4 cycles; 1 gap cycle; 000010 with 1101101 for 4 cycles; … digit 5 shows 1011011; frame repeats every 30 cycles.
- bcd_in changes 0x000000→0x123456 mid-frame → displayed digits unchanged until the next frame_tick, then digit 0 shows 1111101 (6).
- blink_mask=000011, BLINK_HALF=8 → digits 0 and 1 alternately lit and blank every 8 cycles; dig_sel still one-hot throughout; other digits always lit.
- blank_lz=1, bcd_in=0x091500 → digit 5 seg=0; then bcd_in=0x101500 → after the next snapshot, digit 5 shows 0000110.
- Digit 2 = 4'hC → seg 1000000; enable dropped mid-SHOW → next cycle dig_sel=0, seg=0; re-enable → restart at digit 0 with frame_tick.
- rst asserted mid-SHOW → outputs 0 immediately (asynchronous); after release, FSM is in IDLE, then restarts at digit 0.
- SEG_DIMMING_EN defined, brightness=1 → each digit lit 2 of its 4 SHOW cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns {g,f,e,d,c,b,a}
// and the scan FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SHOW = ST_SHOW,
    GAP  = ST_GAP
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decode; non-decimal codes show a dash.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 6-digit seven-segment scanner with per-frame snapshot, blink and
// leading-zero blanking. Optional SEG_DIMMING_EN adds a brightness[1:0] PWM window.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned BLINK_HALF = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp_mask,
`ifdef SEG_DIMMING_EN
  input  logic [1:0]            brightness,
`endif
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned BCD_W = 4 * DIGITS;

  scan_state_t         state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [DIV_W-1:0]    div, div_d;
  logic [BCD_W-1:0]    snap_bcd, snap_bcd_d;
  logic [DIGITS-1:0]   snap_blink, snap_blink_d;
  logic [DIGITS-1:0]   snap_dp, snap_dp_d;
  logic                snap_lz, snap_lz_d;
  logic [BLK_W-1:0]    blink_cnt, blink_cnt_d;
  logic                blink_phase, blink_phase_d;
  logic                tick_d;
  logic                load;
  logic [3:0]          digit_d;
  logic                dp_sel_d;
  logic                blink_sel_d;
  logic [6:0]          seg_dec_c;
  logic                dim_off;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [DIGITS-1:0]   sel_d;
`ifdef SEG_DIMMING_EN
  logic [1:0]          snap_br, snap_br_d;
  logic [31:0]         dim_lim;
`endif

  // Next state: scan sequencing, snapshot capture and the free-running blink timer
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    div_d         = div;
    snap_bcd_d    = snap_bcd;
    snap_blink_d  = snap_blink;
    snap_dp_d     = snap_dp;
    snap_lz_d     = snap_lz;
    tick_d        = 1'b0;
    load          = 1'b0;
    blink_cnt_d   = blink_cnt + BLK_W'(1);
    blink_phase_d = blink_phase;
`ifdef SEG_DIMMING_EN
    snap_br_d     = snap_br;
`endif

    if (blink_cnt == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase;
    end

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      div_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = SHOW;
          idx_d   = '0;
          div_d   = '0;
          load    = 1'b1;
        end
        SHOW: begin
          if (div == DIV_W'(SCAN_DIV - 1)) begin
            state_d = GAP;
            div_d   = '0;
          end else begin
            div_d = div + DIV_W'(1);
          end
        end
        GAP: begin
          state_d = SHOW;
          div_d   = '0;
          if (idx == IDX_W'(DIGITS - 1)) begin
            idx_d = '0;
            load  = 1'b1;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new frame starts: freeze all display inputs for its duration
    if (load) begin
      snap_bcd_d   = bcd_in;
      snap_blink_d = blink_mask;
      snap_dp_d    = dp_mask;
      snap_lz_d    = blank_lz;
      tick_d       = 1'b1;
`ifdef SEG_DIMMING_EN
      snap_br_d    = brightness;
`endif
    end
  end

  // Select the snapshot fields of the digit that will be lit next cycle
  always_comb begin
    digit_d     = 4'd0;
    dp_sel_d    = 1'b0;
    blink_sel_d = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        digit_d     = snap_bcd_d[4*i +: 4];
        dp_sel_d    = snap_dp_d[i];
        blink_sel_d = snap_blink_d[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd   (digit_d),
    .seg_c (seg_dec_c)
  );

`ifdef SEG_DIMMING_EN
  always_comb begin
    dim_lim = ((32'(snap_br_d) + 32'd1) * 32'(SCAN_DIV)) / 32'd4;
    dim_off = (32'(div_d) >= dim_lim);
  end
`else
  assign dim_off = 1'b0;
`endif

  // Output values for the coming cycle; blanking keeps the digit selected
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    sel_d = '0;
    if (state_d == SHOW) begin
      sel_d = DIGITS'(1) << idx_d;
      if (!((blink_sel_d && blink_phase_d) ||
            (snap_lz_d && (idx_d == IDX_W'(DIGITS - 1)) && (digit_d == 4'd0)) ||
            dim_off)) begin
        seg_d = seg_dec_c;
        dp_d  = dp_sel_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      div         <= '0;
      snap_bcd    <= '0;
      snap_blink  <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_out     <= SEG_BLANK;
      dp_out      <= 1'b0;
      dig_sel     <= '0;
      frame_tick  <= 1'b0;
`ifdef SEG_DIMMING_EN
      snap_br     <= 2'd0;
`endif
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      div         <= div_d;
      snap_bcd    <= snap_bcd_d;
      snap_blink  <= snap_blink_d;
      snap_dp     <= snap_dp_d;
      snap_lz     <= snap_lz_d;
      blink_cnt   <= blink_cnt_d;
      blink_phase <= blink_phase_d;
      seg_out     <= seg_d;
      dp_out      <= dp_d;
      dig_sel     <= sel_d;
      frame_tick  <= tick_d;
`ifdef SEG_DIMMING_EN
      snap_br     <= snap_br_d;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: frame-position reference model feeding a
// scoreboard queue, a table of per-digit decode vectors, and hand-written corner sequences.
module tb_seg_scan_driver;

  localparam int DIGITS     = 6;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_HALF = 8;
  localparam int SLOT       = SCAN_DIV + 1;
  localparam int FRAME      = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] bcd_in = '0;
  logic [5:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [5:0]  dp_mask = '0;
`ifdef SEG_DIMMING_EN
  logic [1:0]  brightness = 2'd3;
`endif
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [5:0]  dig_sel;
  logic        frame_tick;

  seg_scan_driver #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bcd_in     (bcd_in),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
`ifdef SEG_DIMMING_EN
    .brightness (brightness),
`endif
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] sel;
    logic       tick;
  } obs_t;

  typedef struct packed {
    logic [23:0]     bcd;
    logic            lz;
    logic [5:0]      dp;
    logic [5:0][6:0] segs;
    logic [5:0]      dpx;
  } vec_t;

  logic [6:0] dec_tbl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                               7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  obs_t  sb_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string tag = "init";

  // Reference model state: frame position rather than FSM state
  bit          m_run;
  int          m_pos;
  int          m_bcnt;
  bit          m_phase;
  bit          m_tick;
  logic [23:0] s_bcd;
  logic [5:0]  s_blink;
  logic [5:0]  s_dp;
  logic        s_lz;
  logic [1:0]  s_br;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_bcnt = 0; m_phase = 0; m_tick = 0;
    s_bcd = '0; s_blink = '0; s_dp = '0; s_lz = 1'b0;
`ifdef SEG_DIMMING_EN
    s_br = 2'd0;
`else
    s_br = 2'd3;
`endif
  endtask

  task automatic take_snap();
    s_bcd = bcd_in; s_blink = blink_mask; s_dp = dp_mask; s_lz = blank_lz;
`ifdef SEG_DIMMING_EN
    s_br = brightness;
`endif
    m_tick = 1;
  endtask

  task automatic model_edge();
    m_tick = 0;
    if (m_bcnt == BLINK_HALF - 1) begin
      m_bcnt = 0;
      m_phase = !m_phase;
    end else begin
      m_bcnt++;
    end
    if (!enable) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_pos = 0;
      take_snap();
    end else begin
      m_pos++;
      if (m_pos == FRAME) begin
        m_pos = 0;
        take_snap();
      end
    end
  endtask

  function automatic obs_t model_out();
    obs_t       e;
    int         dig;
    int         slot;
    int         lim;
    logic [3:0] val;
    bit         off;
    e = '0;
    e.tick = m_tick;
    if (m_run && (m_pos % SLOT) < SCAN_DIV) begin
      dig  = m_pos / SLOT;
      slot = m_pos % SLOT;
      e.sel = 6'(1 << dig);
      val  = s_bcd[dig*4 +: 4];
      lim  = ((int'(s_br) + 1) * SCAN_DIV) / 4;
      off  = (s_blink[dig] && m_phase) || (dig == DIGITS - 1 && s_lz && val == 4'd0) || (slot >= lim);
      if (!off) begin
        e.seg = dec_tbl[val];
        e.dp  = s_dp[dig];
      end
    end
    return e;
  endfunction

  task automatic cmp_obs(string name, obs_t e);
    n_vec++;
    if (seg_out !== e.seg || dp_out !== e.dp || dig_sel !== e.sel || frame_tick !== e.tick) begin
      n_bad++;
      $display("FAIL %s @%0t: got seg=%b dp=%b sel=%b tick=%b, expected seg=%b dp=%b sel=%b tick=%b",
               name, $time, seg_out, dp_out, dig_sel, frame_tick, e.seg, e.dp, e.sel, e.tick);
    end
  endtask

  task automatic cmp8(string name, logic [7:0] got, logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  // One clock: model predicts, scoreboard holds it, DUT output is checked after the edge
  task automatic step();
    obs_t e;
    model_edge();
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    cmp_obs(tag, e);
  endtask

  task automatic restart();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int on_cnt;
    int lit_cnt;

    tbl[0] = '{24'h235959, 1'b0, 6'b000000,
               {7'b1011011, 7'b1001111, 7'b1101101, 7'b1101111, 7'b1101101, 7'b1101111}, 6'b000000};
    tbl[1] = '{24'h091500, 1'b1, 6'b000100,
               {7'b0000000, 7'b1101111, 7'b0000110, 7'b1101101, 7'b0111111, 7'b0111111}, 6'b000100};
    tbl[2] = '{24'h101500, 1'b1, 6'b000000,
               {7'b0000110, 7'b0111111, 7'b0000110, 7'b1101101, 7'b0111111, 7'b0111111}, 6'b000000};
    tbl[3] = '{24'h123C56, 1'b1, 6'b111111,
               {7'b0000110, 7'b1011011, 7'b1001111, 7'b1000000, 7'b1101101, 7'b1111101}, 6'b111111};
    tbl[4] = '{24'h000000, 1'b1, 6'b100001,
               {7'b0000000, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, 6'b000001};
    tbl[5] = '{24'h7849FE, 1'b0, 6'b000000,
               {7'b0000111, 7'b1111111, 7'b1100110, 7'b1101111, 7'b1000000, 7'b1000000}, 6'b000000};

    // Reset state
    model_reset();
    #1;
    tag = "reset";
    cmp_obs(tag, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bcd_in = 24'h235959;
    enable = 1'b1;
    rst = 1'b1;

    // First frame after reset: tick on cycle 1, 30-cycle period
    tag = "startup";
    step();
    cmp8("start_tick", 8'(frame_tick), 8'd1);
    cmp8("start_sel", 8'(dig_sel), 8'h01);
    cmp8("start_seg", 8'(seg_out), 8'(7'b1101111));
    for (int c = 2; c <= 2 * FRAME + 1; c++) begin
      step();
      cmp8("tick_period", 8'(frame_tick), 8'((c % FRAME) == 1));
    end

    // Decode/blanking table, one full frame per entry
    for (int k = 0; k < 6; k++) begin
      $sformat(tag, "vec%0d", k);
      bcd_in = tbl[k].bcd;
      blank_lz = tbl[k].lz;
      dp_mask = tbl[k].dp;
      blink_mask = '0;
      restart();
      for (int c = 0; c < FRAME; c++) begin
        step();
        for (int i = 0; i < DIGITS; i++)
          if (dig_sel == (6'b1 << i))
            cmp8(tag, {dp_out, seg_out}, {tbl[k].dpx[i], tbl[k].segs[i]});
      end
    end
    blank_lz = 1'b0;
    dp_mask = '0;

    // Mid-frame input change is invisible until the next snapshot
    tag = "midframe";
    bcd_in = 24'h000000;
    restart();
    repeat (12) step();
    bcd_in = 24'h123456;
    found = 0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      step();
      if (frame_tick) found = 1;
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL midframe_timeout: no frame_tick within %0d cycles, expected one", 2 * FRAME);
    end else begin
      cmp8("mf_sel", 8'(dig_sel), 8'h01);
      cmp8("mf_seg", 8'(seg_out), 8'(7'b1111101));
    end

    // Blinking digits 0 and 1
    tag = "blink";
    bcd_in = 24'h235959;
    blink_mask = 6'b000011;
    restart();
    for (int c = 0; c < 4 * FRAME; c++) begin
      step();
      cmp8("onehot0", 8'($onehot0(dig_sel)), 8'd1);
    end
    blink_mask = '0;

    // Enable dropped mid-SHOW, then re-enabled
    tag = "enable";
    bcd_in = 24'h123C56;
    restart();
    repeat (7) step();
    enable = 1'b0;
    step();
    cmp8("en_off", {dig_sel, frame_tick, dp_out}, 8'h00);
    cmp8("en_off_seg", 8'(seg_out), 8'h00);
    repeat (3) step();
    enable = 1'b1;
    step();
    cmp8("reen_tick", 8'(frame_tick), 8'd1);
    cmp8("reen_sel", 8'(dig_sel), 8'h01);
    cmp8("reen_seg", 8'(seg_out), 8'(7'b1111101));
    repeat (FRAME) step();

    // Asynchronous reset mid-SHOW
    tag = "async_rst";
    restart();
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    cmp_obs("async_rst_now", '0);
    model_reset();
    @(posedge clk);
    #1;
    cmp_obs("async_rst_held", '0);
    rst = 1'b1;
    step();
    cmp8("rst_restart_sel", 8'(dig_sel), 8'h01);
    cmp8("rst_restart_tick", 8'(frame_tick), 8'd1);
    repeat (FRAME) step();

`ifdef SEG_DIMMING_EN
    // Quarter-step dimming: brightness 1 lights 2 of 4 SHOW cycles
    tag = "dim";
    bcd_in = 24'h888888;
    brightness = 2'd1;
    restart();
    on_cnt = 0;
    lit_cnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (dig_sel != '0) on_cnt++;
      if (seg_out != '0) lit_cnt++;
    end
    cmp8("dim_on", 8'(on_cnt), 8'd24);
    cmp8("dim_lit", 8'(lit_cnt), 8'd12);
    brightness = 2'd3;
    repeat (FRAME) step();
`else
    on_cnt = 0;
    lit_cnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
